// File: rtl/bus_periph_pkg.sv
// rtl/bus_periph_pkg.sv - shared register map constants for CPU bus responders
package bus_periph_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_THRESH = 2'd3
    } reg_idx_e;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_UNF       = 3;
    localparam int ST_LEVEL_LSB = 16;
    localparam int ST_LEVEL_W   = 9;

    localparam int CTL_FLUSH    = 0;
    localparam int CTL_CLR_ERR  = 1;

    localparam int THRESH_W     = 9;

    // Read response state: idle, or holding data until the strobe drops
    typedef enum logic {
        RSP_IDLE = 1'b0,
        RSP_HOLD = 1'b1
    } rsp_state_e;

    function automatic logic [31:0] pack_status(
        input logic                  empty,
        input logic                  full,
        input logic                  ovf,
        input logic                  unf,
        input logic [ST_LEVEL_W-1:0] level
    );
        logic [31:0] s;
        s                            = '0;
        s[ST_EMPTY]                  = empty;
        s[ST_FULL]                   = full;
        s[ST_OVF]                    = ovf;
        s[ST_UNF]                    = unf;
        s[ST_LEVEL_LSB +: ST_LEVEL_W] = level;
        return s;
    endfunction

endpackage

// File: rtl/bus_fifo_periph_if.sv
// rtl/bus_fifo_periph_if.sv - strobed CPU bus between initiator and responder
interface bus_fifo_periph_if #(
    parameter int ADDR_W = 7
);
    logic              i_stb;
    logic              i_we;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_data;
    logic [31:0]       o_data;
    logic              o_data_ready;

    modport master (
        output i_stb, i_we, i_addr, i_data,
        input  o_data, o_data_ready
    );

    modport slave (
        input  i_stb, i_we, i_addr, i_data,
        output o_data, o_data_ready
    );
endinterface

// File: rtl/bus_fifo_periph_fifo_mem.sv
// rtl/bus_fifo_periph_fifo_mem.sv - DEPTH x 32 storage, sync write, async read
module fifo_mem #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [31:0]      rdata
);
    logic [31:0] mem [DEPTH];

    // Storage has no reset; only pointer-addressed words are ever read back
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/bus_fifo_periph.sv
// rtl/bus_fifo_periph.sv - word FIFO bus responder; FIFO_IRQ_EN enables THRESH and o_irq
module bus_fifo_periph
    import bus_periph_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 7
) (
    input  logic              i_clk,
    input  logic              i_rst,
    bus_fifo_periph_if.slave  bus,
    output logic              o_irq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic             stb_q;
    logic             start;
    logic             in_range;
    reg_idx_e         reg_sel;
    logic             wr_fire;
    logic             rd_req;
    logic             push;
    logic             pop;
    logic             ctl_wr;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [LVL_W-1:0] level;
    logic             ovf;
    logic             unf;
    logic             empty;
    logic             full;
    logic [ST_LEVEL_W-1:0] level9;
    logic [31:0]      mem_rdata;
    logic [31:0]      thresh_rd;
    logic [31:0]      rd_word;
    rsp_state_e       state_q;
    rsp_state_e       state_d;
    logic             rsp_load;
    logic             rsp_clear;

    assign start    = bus.i_stb && !stb_q;
    assign in_range = (bus.i_addr[ADDR_W-1:4] == '0);
    assign reg_sel  = reg_idx_e'(bus.i_addr[3:2]);
    assign wr_fire  = start && bus.i_we && in_range;
    assign rd_req   = start && !bus.i_we;
    assign push     = wr_fire && (reg_sel == REG_DATA);
    assign pop      = rd_req && in_range && (reg_sel == REG_DATA);
    assign ctl_wr   = wr_fire && (reg_sel == REG_CTRL);
    assign empty    = (level == '0);
    assign full     = (level == LVL_W'(DEPTH));
    assign level9   = ST_LEVEL_W'(level);

    wire unused_addr = &{1'b0, bus.i_addr[1:0]};

    // Strobe history resets high so a strobe held through reset release is ignored
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stb_q <= 1'b1;
        end else begin
            stb_q <= bus.i_stb;
        end
    end

    // Pointers, level and sticky error flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (push) begin
                if (full) begin
                    ovf <= 1'b1;
                end else begin
                    wptr  <= wptr + PTR_W'(1);
                    level <= level + LVL_W'(1);
                end
            end
            if (pop) begin
                if (empty) begin
                    unf <= 1'b1;
                end else begin
                    rptr  <= rptr + PTR_W'(1);
                    level <= level - LVL_W'(1);
                end
            end
            if (ctl_wr) begin
                if (bus.i_data[CTL_FLUSH]) begin
                    wptr  <= '0;
                    rptr  <= '0;
                    level <= '0;
                end
                if (bus.i_data[CTL_CLR_ERR]) begin
                    ovf <= 1'b0;
                    unf <= 1'b0;
                end
            end
        end
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (i_clk),
        .we    (push && !full),
        .waddr (wptr),
        .wdata (bus.i_data),
        .raddr (rptr),
        .rdata (mem_rdata)
    );

`ifdef FIFO_IRQ_EN
    logic [THRESH_W-1:0] thresh_q;

    // Software threshold for the level interrupt
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            thresh_q <= THRESH_W'(DEPTH);
        end else if (wr_fire && (reg_sel == REG_THRESH)) begin
            thresh_q <= bus.i_data[THRESH_W-1:0];
        end
    end

    // Interrupt registered one cycle behind level/threshold; zero threshold disables it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_irq <= 1'b0;
        end else begin
            o_irq <= (level9 >= thresh_q) && (thresh_q != '0);
        end
    end

    assign thresh_rd = 32'(thresh_q);
`else
    assign o_irq     = 1'b0;
    assign thresh_rd = '0;
`endif

    // Read mux; out-of-range and write-only registers read as zero
    always_comb begin
        rd_word = '0;
        if (in_range) begin
            case (reg_sel)
                REG_DATA:   rd_word = empty ? 32'h0 : mem_rdata;
                REG_STATUS: rd_word = pack_status(empty, full, ovf, unf, level9);
                REG_CTRL:   rd_word = '0;
                REG_THRESH: rd_word = thresh_rd;
                default:    rd_word = '0;
            endcase
        end
    end

    // Response state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= RSP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture read data on start, hold it until the strobe is seen low
    always_comb begin
        state_d   = state_q;
        rsp_load  = 1'b0;
        rsp_clear = 1'b0;
        case (state_q)
            RSP_IDLE: begin
                if (rd_req) begin
                    rsp_load = 1'b1;
                    state_d  = RSP_HOLD;
                end
            end
            RSP_HOLD: begin
                if (!bus.i_stb) begin
                    rsp_clear = 1'b1;
                    state_d   = RSP_IDLE;
                end
            end
            default: state_d = RSP_IDLE;
        endcase
    end

    // Registered read data and ready
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_data       <= '0;
            bus.o_data_ready <= 1'b0;
        end else if (rsp_load) begin
            bus.o_data       <= rd_word;
            bus.o_data_ready <= 1'b1;
        end else if (rsp_clear) begin
            bus.o_data       <= '0;
            bus.o_data_ready <= 1'b0;
        end
    end
endmodule

// File: doc/bus_fifo_periph.md
# bus_fifo_periph

Word-wide FIFO responder on the 32-bit CPU memory/peripheral bus: the bus-side counterpart of the CPU's initiator port, answering strobed reads and writes with a registered data/ready handshake. The CPU pushes words by writing the DATA register and pops them by reading it. STATUS, CONTROL and THRESH registers give level and error visibility. It sits beside the text-area peripheral behind the top-level address decode, in the CPU clock domain.

## Interface
- DEPTH, 16: FIFO entries; power of two, 2..256.
- ADDR_W, 7: width of the bus address slice seen by this block.
- i_clk  in  1: CPU clock, 100 MHz domain.
- i_rst  in  1: reset; asynchronous, active-high.
- i_stb  in  1: bus strobe, driven from CPU `o_bus_clk`; a transaction starts on its rising edge.
- i_we  in  1: 1 = write, 0 = read; sampled at strobe rise.
- i_addr  in  ADDR_W: byte address; bits [3:2] select the register.
- i_data  in  32: write data; sampled at strobe rise.
- o_data  out  32: read data.
- o_data_ready  out  1: read data valid.
- o_irq  out  1: level at or above the threshold (only with FIFO_IRQ_EN).

## Operation
- Start event S: i_stb=1 registered in the cycle where i_stb was 0 on the previous i_clk edge. Exactly one access per strobe high period; a held strobe never repeats an access.
- Register map, by i_addr[3:2]; i_addr[ADDR_W-1:4] must be 0, otherwise the write is ignored and the read returns 0:
  - 0 DATA: a write pushes i_data. A read pops the head word.
  - 1 STATUS (RO): [0] empty, [1] full, [2] overflow (sticky), [3] underflow (sticky), [16+:9] level 0..DEPTH. Other bits are 0.
  - 2 CONTROL (WO, reads 0): a write with bit0=1 flushes (pointers and level go to 0). A write with bit1=1 clears both sticky flags. Both bits may be set in one write.
  - 3 THRESH: see Configuration.
- Push while full: the word is dropped, overflow is set, and the pointers do not change.
- Pop while empty: returns 0, underflow is set, and the pointers do not change.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Level is a separate counter of log2(DEPTH)+1 bits.
- Writes to STATUS are ignored. An out-of-range write never sets a sticky flag.

## Timing
- Reset values: o_data=0, o_data_ready=0, o_irq=0, pointers=0, level=0, sticky flags=0, THRESH=DEPTH. The strobe-edge history register resets to 1, so a strobe that is already high at reset release is ignored.
- Write: the state update is visible on the edge ending cycle S, so a STATUS read started in cycle S+1 already reflects it.
- Read: data is sampled in cycle S and registered. o_data and o_data_ready=1 are valid from S+1. Pop side effects (pointer, level, underflow) commit at the end of S.
- Both outputs hold until i_stb is sampled low. o_data_ready then drops on the next edge, and o_data returns to 0 on that same edge.
- Write transactions never assert o_data_ready.
- Assertion of i_rst at any point, including mid-read, clears everything at once. A strobe in flight is dropped and is not replayed after release.
- o_irq is registered and updates one cycle after the level or THRESH changes.

## Configuration
- FIFO_IRQ_EN defined:
  - THRESH (addr 3) is read/write, using bits [8:0].
  - o_irq = (level >= THRESH) && (THRESH != 0).
- FIFO_IRQ_EN undefined:
  - THRESH reads 0 and writes to it are ignored.
  - o_irq is tied to 0.
  - No threshold flops are synthesized.
  - The port list is unchanged.

## Structure
- Shared package bus_periph_pkg holds:
  - register index constants REG_DATA=0, REG_STATUS=1, REG_CTRL=2, REG_THRESH=3;
  - STATUS bit positions (ST_EMPTY, ST_FULL, ST_OVF, ST_UNF, ST_LEVEL_LSB=16);
  - CONTROL bit positions (CTL_FLUSH, CTL_CLR_ERR).
  The text-area peripheral and future bus responders reuse this package.
- One sub-module, fifo_mem: DEPTH x 32 storage with a synchronous write port and an asynchronous read port addressed by the read pointer. The read is combinational within cycle S and is captured into o_data.

## Test plan
- Reset, then read STATUS -> o_data_ready at S+1, o_data=0x00000001 (empty, level 0).
- Push 0x11111111, 0x22222222, 0x33333333, then read DATA three times -> returns in order. A further read -> 0, and STATUS = 0x00000009 (empty plus underflow).
- DEPTH=16: push 17 words -> STATUS = 0x00100006 (level 16, full, overflow). Write CONTROL=0x3 -> STATUS = 0x00000001.
- Push and pop 40 words interleaved with level 0..3 -> all data matches and the pointer wrap is invisible. Hold i_stb high for 10 cycles on one DATA read -> exactly one pop.
- FIFO_IRQ_EN, THRESH=4: push 3 -> o_irq=0; the 4th push -> o_irq=1 one cycle after the level update; one pop -> o_irq=0. Without the macro -> o_irq stays 0 and THRESH reads 0.
- Assert i_rst in cycle S+1 of a DATA read -> o_data_ready=0 and o_data=0 immediately, and STATUS after release reads 0x00000001.
